// File: rtl/spi_master_mc_if.sv
// Control/handshake and SPI pin bundle for spi_master_mc.
// master = the SPI master block, slave = firmware side plus the SPI device.
interface spi_master_mc_if #(
   parameter int DATA_W = 32,
   parameter int NCS    = 4,
   parameter int DIV_W  = 16
);
   localparam int NBW = $clog2(DATA_W);
   localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic [NBW-1:0]    nbits;
   logic [CSW-1:0]    cs_sel;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic [DIV_W-1:0]  div;
   logic              start;
   logic              busy;
   logic              done;
   logic [NCS-1:0]    spi_csn;
   logic              spi_sck;
   logic              spi_mosi;
   logic              spi_miso;

   modport master (
      input  tx_data, nbits, cs_sel, cpol, cpha, lsb_first, div, start,
      input  spi_miso,
      output rx_data, busy, done, spi_csn, spi_sck, spi_mosi
   );

   modport slave (
      output tx_data, nbits, cs_sel, cpol, cpha, lsb_first, div, start,
      output spi_miso,
      input  rx_data, busy, done, spi_csn, spi_sck, spi_mosi
   );
endinterface

// File: rtl/spi_master_mc.sv
// SPI master: runtime width, CS index, CPOL/CPHA, bit order and divider.
// Registered outputs; start/busy/done handshake towards firmware logic.
module spi_master_mc #(
   parameter int DATA_W = 32,
   parameter int NCS    = 4,
   parameter int DIV_W  = 16
) (
   input  logic          clk,
   input  logic          nrst,
   spi_master_mc_if.master bus
);
   localparam int NBW  = $clog2(DATA_W);
   localparam int CNTW = NBW + 1;
   localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LEAD,
      S_HOLD,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [CNTW-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [NBW-1:0]    nb_q, nb_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [NCS-1:0]    csn_q, csn_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;

   logic              phase_end;
   logic              last;

   // Bit ordinal (0 = first on the wire) to position in the data word.
   function automatic logic [NBW-1:0] bit_idx(
      input logic [NBW-1:0] ord,
      input logic [NBW-1:0] nb,
      input logic           lsb
   );
      bit_idx = lsb ? ord : nb - ord;
   endfunction

   assign phase_end = (cnt_q == div_q);
   assign last      = (bit_q == CNTW'(nb_q) + CNTW'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      nb_d    = nb_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      div_d   = div_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      csn_d   = csn_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;

      unique case (state_q)
         S_IDLE: begin
            sck_d  = bus.cpol;
            mosi_d = 1'b1;
            cnt_d  = '0;
            bit_d  = '0;
            if (bus.start) begin
               tx_d    = bus.tx_data;
               nb_d    = bus.nbits;
               cpol_d  = bus.cpol;
               cpha_d  = bus.cpha;
               lsb_d   = bus.lsb_first;
               div_d   = bus.div;
               rx_sh_d = '0;
               busy_d  = 1'b1;
               state_d = S_SETUP;
               for (int i = 0; i < NCS; i++)
                  csn_d[i] = !(bus.cs_sel == CSW'(i));
               if (!bus.cpha)
                  mosi_d = bus.tx_data[bit_idx('0, bus.nbits,
                                               bus.lsb_first)];
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               cnt_d = '0;
               if (last) begin
                  state_d = S_HOLD;
               end else begin
                  sck_d   = ~cpol_q;
                  state_d = S_LEAD;
                  if (!cpha_q)
                     rx_sh_d[bit_idx(bit_q[NBW-1:0], nb_q, lsb_q)] =
                        bus.spi_miso;
                  else
                     mosi_d = tx_q[bit_idx(bit_q[NBW-1:0], nb_q, lsb_q)];
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_LEAD: begin
            if (phase_end) begin
               cnt_d   = '0;
               sck_d   = cpol_q;
               bit_d   = bit_q + CNTW'(1);
               state_d = S_SETUP;
               if (cpha_q)
                  rx_sh_d[bit_idx(bit_q[NBW-1:0], nb_q, lsb_q)] =
                     bus.spi_miso;
               else if (bit_q < CNTW'(nb_q))
                  mosi_d = tx_q[bit_idx(bit_q[NBW-1:0] + NBW'(1),
                                        nb_q, lsb_q)];
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_HOLD: begin
            if (phase_end) begin
               cnt_d   = '0;
               csn_d   = '1;
               mosi_d  = 1'b1;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_GAP: begin
            if (phase_end) begin
               cnt_d   = '0;
               rx_d    = rx_sh_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_sh_q <= '0;
         rx_q    <= '0;
         nb_q    <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         csn_q   <= '1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
         nb_q    <= nb_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         csn_q   <= csn_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
      end
   end

   assign bus.rx_data  = rx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.spi_csn  = csn_q;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_mosi = mosi_q;
endmodule
